// File: rtl/egress_cell_reasm.sv
// egress_cell_reasm
//   Per-port egress stage. Takes 4-beat x 128-bit cells from the switch core,
//   buffers them, reassembles complete frames and streams each frame to the
//   MAC TX one byte per handshake. The first beat of every frame is a
//   descriptor whose bits [10:0] hold the frame byte length.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   cell_wr, cell_din      cell beat strobe (4 consecutive cycles) and data
//   cell_first, cell_last  frame delimiters, stable across a cell
//   cell_bp                registered backpressure to the core
//   tx_data/valid/ready    byte stream to the MAC, tx_sof/tx_eof framing
//   frame_drop             one-cycle pulse per discarded frame or cell
//   buf_used               words held, committed plus in-progress
//
// Ingress FSM
//   state    | meaning
//   IN_IDLE  | between frames; a cell without cell_first is discarded
//   IN_FRAME | collecting cells of a frame starting at commit_ptr
//
// Egress FSM
//   state    | meaning
//   EG_IDLE  | wait for a completed frame record
//   EG_FETCH | RAM read of the next payload word into the shift register
//   EG_SHIFT | present bytes MSB first, advance on tx handshake
//   EG_SKIP  | release the frame, rd_ptr jumps over padding words
module egress_cell_reasm #(
    parameter int ADDR_W    = 8,
    parameter int LFIFO_AW  = 4,
    parameter int BP_MARGIN = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cell_wr,
    input  logic [127:0]      cell_din,
    input  logic              cell_first,
    input  logic              cell_last,
    output logic              cell_bp,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              frame_drop,
    output logic [ADDR_W:0]   buf_used
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LDEPTH = 1 << LFIFO_AW;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   MARGIN_V = (ADDR_W+1)'(BP_MARGIN);
    localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CELL_W   = (ADDR_W+1)'(4);
    localparam logic [LFIFO_AW:0] LDEPTH_V = (LFIFO_AW+1)'(LDEPTH);
    localparam logic [LFIFO_AW:0] LCNT_ONE = (LFIFO_AW+1)'(1);

    typedef enum logic {IN_IDLE, IN_FRAME} in_state_t;
    typedef enum logic [1:0] {EG_IDLE, EG_FETCH, EG_SHIFT, EG_SKIP} eg_state_t;

    logic [127:0] mem [DEPTH];
    logic [19:0]  lf_mem [LDEPTH];

    in_state_t         in_state;
    logic [1:0]        beat_cnt;
    logic              discard;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   commit_ptr;
    logic [10:0]       byte_len;
    logic [8:0]        word_cnt;

    logic [LFIFO_AW-1:0] lf_wp;
    logic [LFIFO_AW-1:0] lf_rp;
    logic [LFIFO_AW:0]   lf_cnt;

    eg_state_t         eg_state;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [127:0]      shreg;
    logic [3:0]        byte_idx;
    logic [10:0]       byte_cnt;
    logic [10:0]       cur_len;
    logic [8:0]        cur_wcnt;

    // A new frame restarts at commit_ptr, so its space check must be made
    // against the rewound pointer rather than the abandoned partial frame.
    logic              beat0;
    logic [ADDR_W:0]   start_ptr;
    logic [ADDR_W:0]   start_free;
    logic              no_space;
    logic              orphan;
    logic              accept0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              len_ok;
    logic              push;
    logic              pop;

    assign beat0      = cell_wr && (beat_cnt == 2'd0);
    assign start_ptr  = cell_first ? commit_ptr : wr_ptr;
    assign start_free = DEPTH_V - (start_ptr - rd_ptr);
    assign no_space   = (start_free < CELL_W) || (lf_cnt == LDEPTH_V);
    assign orphan     = !cell_first && (in_state == IN_IDLE);
    assign accept0    = beat0 && !orphan && !no_space;
    assign wr_en      = accept0 || (cell_wr && (beat_cnt != 2'd0) && !discard);
    assign wr_addr    = accept0 ? start_ptr[ADDR_W-1:0] : wr_ptr[ADDR_W-1:0];
    // On beat 3 word_cnt still excludes the current beat, i.e. it already
    // equals the payload word count (total words minus the descriptor).
    assign len_ok     = (byte_len != 11'd0) && ({2'b00, byte_len} <= {word_cnt, 4'b0000});
    assign push       = cell_wr && (beat_cnt == 2'd3) && !discard && cell_last && len_ok;
    assign pop        = (eg_state == EG_SKIP);

    assign buf_used   = wr_ptr - rd_ptr;
    assign tx_data    = shreg[127:120];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= cell_din;
        if (push)  lf_mem[lf_wp] <= {word_cnt + 9'd1, byte_len};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_state   <= IN_IDLE;
            beat_cnt   <= 2'd0;
            discard    <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            byte_len   <= '0;
            word_cnt   <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            if (cell_wr) beat_cnt <= beat_cnt + 2'd1;
            if (beat0) begin
                if (orphan) begin
                    discard    <= 1'b1;
                    frame_drop <= 1'b1;
                end else if (no_space) begin
                    discard    <= 1'b1;
                    frame_drop <= 1'b1;
                    wr_ptr     <= commit_ptr;
                    in_state   <= IN_IDLE;
                end else begin
                    discard <= 1'b0;
                    wr_ptr  <= start_ptr + PTR_ONE;
                    if (cell_first) begin
                        in_state <= IN_FRAME;
                        byte_len <= cell_din[10:0];
                        word_cnt <= 9'd1;
                        if (in_state == IN_FRAME) frame_drop <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 9'd1;
                    end
                end
            end else if (cell_wr && !discard) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                word_cnt <= word_cnt + 9'd1;
                if ((beat_cnt == 2'd3) && cell_last) begin
                    in_state <= IN_IDLE;
                    if (len_ok) begin
                        commit_ptr <= wr_ptr + PTR_ONE;
                    end else begin
                        wr_ptr     <= commit_ptr;
                        frame_drop <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lf_wp   <= '0;
            lf_rp   <= '0;
            lf_cnt  <= '0;
            cell_bp <= 1'b0;
        end else begin
            if (push) lf_wp <= lf_wp + 1'b1;
            if (pop)  lf_rp <= lf_rp + 1'b1;
            case ({push, pop})
                2'b10:   lf_cnt <= lf_cnt + LCNT_ONE;
                2'b01:   lf_cnt <= lf_cnt - LCNT_ONE;
                default: lf_cnt <= lf_cnt;
            endcase
            cell_bp <= ((DEPTH_V - buf_used) < MARGIN_V) || ((LDEPTH_V - lf_cnt) <= LCNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eg_state <= EG_IDLE;
            rd_ptr   <= '0;
            rd_addr  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            byte_cnt <= '0;
            cur_len  <= '0;
            cur_wcnt <= '0;
            tx_valid <= 1'b0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
        end else begin
            case (eg_state)
                EG_IDLE: begin
                    if (lf_cnt != '0) begin
                        {cur_wcnt, cur_len} <= lf_mem[lf_rp];
                        rd_addr  <= rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
                        byte_cnt <= '0;
                        eg_state <= EG_FETCH;
                    end
                end
                EG_FETCH: begin
                    shreg    <= mem[rd_addr];
                    byte_idx <= '0;
                    tx_valid <= 1'b1;
                    tx_sof   <= (byte_cnt == 11'd0);
                    tx_eof   <= ({1'b0, byte_cnt} + 12'd1 == {1'b0, cur_len});
                    eg_state <= EG_SHIFT;
                end
                EG_SHIFT: begin
                    if (tx_ready) begin
                        if (tx_eof) begin
                            tx_valid <= 1'b0;
                            tx_sof   <= 1'b0;
                            tx_eof   <= 1'b0;
                            eg_state <= EG_SKIP;
                        end else begin
                            byte_cnt <= byte_cnt + 11'd1;
                            tx_sof   <= 1'b0;
                            if (byte_idx == 4'd15) begin
                                tx_valid <= 1'b0;
                                rd_addr  <= rd_addr + ADDR_W'(1);
                                eg_state <= EG_FETCH;
                            end else begin
                                shreg    <= {shreg[119:0], 8'h00};
                                byte_idx <= byte_idx + 4'd1;
                                tx_eof   <= ({1'b0, byte_cnt} + 12'd2 == {1'b0, cur_len});
                            end
                        end
                    end
                end
                default: begin
                    rd_ptr   <= rd_ptr + (ADDR_W+1)'(cur_wcnt);
                    eg_state <= EG_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_egress_cell_reasm.sv
module tb_egress_cell_reasm;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cell_wr = 1'b0;
    logic [127:0]      cell_din = '0;
    logic              cell_first = 1'b0;
    logic              cell_last = 1'b0;
    logic              cell_bp;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              tx_sof;
    logic              tx_eof;
    logic              frame_drop;
    logic [ADDR_W:0]   buf_used;

    egress_cell_reasm #(.ADDR_W(ADDR_W), .LFIFO_AW(4), .BP_MARGIN(8)) dut (
        .clk(clk), .rstn(rstn), .cell_wr(cell_wr), .cell_din(cell_din),
        .cell_first(cell_first), .cell_last(cell_last), .cell_bp(cell_bp),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sof(tx_sof), .tx_eof(tx_eof), .frame_drop(frame_drop),
        .buf_used(buf_used)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int drops_seen = 0;
    int drops_exp = 0;
    int ready_mode = 3;     // 0 always, 1 toggle, 2 random, 3 never

    logic [9:0]   exp_q[$];  // {byte, sof, eof}
    logic [127:0] m_words[$];
    int           m_len = 0;
    bit           m_in_frame = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] seq_beat(input int base);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[127-8*k -: 8] = 8'(base + k);
        return w;
    endfunction

    // Reference model: frame-level rules, bytes pushed on a valid frame end.
    task automatic model_cell(input bit first, input bit last, input logic [127:0] b0,
                              input logic [127:0] b1, input logic [127:0] b2, input logic [127:0] b3);
        int wc;
        logic [127:0] w;
        if (!first && !m_in_frame) begin
            drops_exp++;
            return;
        end
        if (first) begin
            if (m_in_frame) drops_exp++;
            m_words.delete();
            m_len = int'(b0[10:0]);
            m_in_frame = 1;
        end
        m_words.push_back(b0); m_words.push_back(b1);
        m_words.push_back(b2); m_words.push_back(b3);
        if (last) begin
            m_in_frame = 0;
            wc = m_words.size();
            if (m_len >= 1 && m_len <= (wc - 1) * 16) begin
                for (int i = 0; i < m_len; i++) begin
                    w = m_words[1 + i / 16];
                    exp_q.push_back({w[127-8*(i%16) -: 8], i == 0, i == m_len - 1});
                end
            end else begin
                drops_exp++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cell(input bit first, input bit last, input logic [127:0] b0,
                             input logic [127:0] b1, input logic [127:0] b2, input logic [127:0] b3);
        int guard = 0;
        while (cell_bp && guard < 2000) begin
            tick();
            guard++;
        end
        if (cell_bp) check("bp_wait_timeout", 1, 0);
        model_cell(first, last, b0, b1, b2, b3);
        cell_first = first;
        cell_last  = last;
        cell_wr    = 1'b1;
        cell_din = b0; tick();
        cell_din = b1; tick();
        cell_din = b2; tick();
        cell_din = b3; tick();
        cell_wr = 1'b0;
    endtask

    task automatic send_frame(input int ncells, input int len);
        logic [127:0] b0;
        for (int c = 0; c < ncells; c++) begin
            b0 = rnd128();
            if (c == 0) b0[10:0] = 11'(len);
            send_cell(c == 0, c == ncells - 1, b0, rnd128(), rnd128(), rnd128());
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || tx_valid) && guard < 20000) begin
            tick();
            guard++;
        end
        if (guard >= 20000) begin
            check({name, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (6) tick();
        check({name, "_buf_used"}, 32'(buf_used), 0);
        check({name, "_drops"}, drops_seen, drops_exp);
    endtask

    // tx_ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    logic       stall_prev = 1'b0;
    logic [9:0] held = '0;
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (frame_drop) drops_seen++;
            if (stall_prev) begin
                check("hold_valid", 32'(tx_valid), 1);
                check("hold_data", 32'({tx_data, tx_sof, tx_eof}), 32'(held));
            end
            stall_prev = tx_valid && !tx_ready;
            held = {tx_data, tx_sof, tx_eof};
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'({tx_data, tx_sof, tx_eof}), 32'h400);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'({tx_data, tx_sof, tx_eof}), 32'(e));
                end
            end
        end
    end

    initial begin
        int sent;
        int kind, nc, maxl;
        logic [127:0] b0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_bp", 32'(cell_bp), 0);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_sof_eof", 32'({tx_sof, tx_eof}), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_drop", 32'(frame_drop), 0);
        check("rst_used", 32'(buf_used), 0);
        tick();
        rstn = 1'b1;
        tick();

        // single-cell frame, 40 sequential bytes
        ready_mode = 0;
        b0 = rnd128(); b0[10:0] = 11'd40;
        send_cell(1, 1, b0, seq_beat(0), seq_beat(16), seq_beat(32));
        drain("single");

        // 2-cell 100-byte frame, then a frame right behind it
        send_frame(2, 100);
        send_frame(1, 33);
        drain("two_cell");

        // ready toggling every cycle
        ready_mode = 1;
        send_frame(2, 64);
        drain("toggle");

        // abort by second cell_first
        ready_mode = 0;
        b0 = rnd128(); b0[10:0] = 11'd20;
        send_cell(1, 0, b0, rnd128(), rnd128(), rnd128());
        send_frame(2, 90);
        drain("abort");

        // bad lengths and an orphan cell
        send_frame(1, 0);
        send_frame(1, 60);
        send_cell(0, 1, rnd128(), rnd128(), rnd128(), rnd128());
        send_frame(1, 48);
        drain("bad_len");

        // randomized traffic
        ready_mode = 2;
        for (int i = 0; i < 50; i++) begin
            kind = $urandom_range(0, 9);
            nc   = $urandom_range(1, 4);
            maxl = (nc * 4 - 1) * 16;
            case (kind)
                0: send_cell(0, 1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(), rnd128());
                1: begin
                    b0 = rnd128(); b0[10:0] = 11'($urandom_range(1, 48));
                    send_cell(1, 0, b0, rnd128(), rnd128(), rnd128());
                    send_frame(nc, $urandom_range(1, maxl));
                end
                2: send_frame(nc, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(maxl + 1, 2047));
                default: send_frame(nc, $urandom_range(1, maxl));
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        drain("random");

        // fill with 16-word frames while the MAC is stalled: after 15 frames
        // 240 words are used (16 free) and the record FIFO has 1 free entry
        ready_mode = 3;
        sent = 0;
        for (int f = 0; f < 16; f++) begin
            repeat (2) tick();
            check("fill_bp", 32'(cell_bp), (f == 15) ? 1 : 0);
            if (cell_bp) break;
            send_frame(4, $urandom_range(1, 240));
            sent++;
        end
        check("fill_frames", sent, 15);
        check("fill_used", 32'(buf_used), 240);
        ready_mode = 0;
        drain("fill");
        check("fill_bp_clear", 32'(cell_bp), 0);

        // reset in the middle of a cell, then a clean frame
        b0 = rnd128(); b0[10:0] = 11'd30;
        send_cell(1, 0, b0, rnd128(), rnd128(), rnd128());
        m_in_frame = 0;
        m_words.delete();
        cell_first = 1'b0; cell_last = 1'b0; cell_wr = 1'b1;
        cell_din = rnd128(); tick();
        cell_din = rnd128(); tick();
        cell_wr = 1'b0;
        rstn = 1'b0;
        #2;
        check("midrst_used", 32'(buf_used), 0);
        check("midrst_valid", 32'(tx_valid), 0);
        tick();
        rstn = 1'b1;
        tick();
        send_frame(2, 77);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
